axis_frame_receiver: RTL and testbench

- Sink for the read data path's AXI-Stream video: it consumes beats framed by `tuser` (start of frame) and `tlast` (end of line).
- It checks framing against the configured line length and image height, and tags each pixel with its x/y coordinates.
- It emits line/frame completion pulses and a frame-active level, and resynchronises after protocol errors.
- It sits in the `eim_clk` domain, downstream of the timing generator / read data mux.

---
 rtl/timing_pkg.sv | 26 ++
 rtl/axis_pix_reg.sv | 55 +++++
 rtl/axis_frame_receiver.sv | 179 +++++++++++++++++
 tb/tb_axis_frame_receiver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// rtl/timing_pkg.sv - shared types and constants for the AXI-Stream frame receiver
//
// Purpose: receiver FSM state encoding, err_status bit indices, configuration
//          clamp minimums and a small clamp helper.
// Ports:   none (package).
package timing_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_ACTIVE = 2'd1,
    RX_RESYNC = 2'd2
  } rx_state_e;

  localparam int ERR_ORPHAN      = 0;
  localparam int ERR_EARLY_TLAST = 1;
  localparam int ERR_MISS_TLAST  = 2;
  localparam int ERR_EARLY_SOF   = 3;

  localparam logic [15:0] MIN_H = 16'd2;
  localparam logic [15:0] MIN_V = 16'd1;

  function automatic logic [15:0] clamp_min(input logic [15:0] val, input logic [15:0] lo);
    return (val < lo) ? lo : val;
  endfunction

endpackage

// File: rtl/axis_pix_reg.sv
// rtl/axis_pix_reg.sv - single-stage output register for pixel data and coordinates
//
// Purpose: holds one forwarded pixel with its x/y tag; refills in the same
//          cycle the downstream consumes, so ready depends only on registered
//          state and the downstream ready (no valid->ready path).
// Ports:   clk_i/rst_i           clock, async active-high reset
//          in_valid_i/in_ready_o upstream handshake
//          in_data_i/in_x_i/in_y_i pixel and coordinates to load
//          out_valid_o/out_ready_i downstream handshake
//          out_data_o/out_x_o/out_y_o registered pixel and coordinates
module axis_pix_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [15:0]       in_x_i,
  input  logic [15:0]       in_y_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [15:0]       out_x_o,
  output logic [15:0]       out_y_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       x_q;
  logic [15:0]       y_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_x_o     = x_q;
  assign out_y_o     = y_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q <= in_data_i;
        x_q    <= in_x_i;
        y_q    <= in_y_i;
      end
    end
  end

endmodule

// File: rtl/axis_frame_receiver.sv
// rtl/axis_frame_receiver.sv - AXI-Stream video sink with framing checks and x/y tagging
//
// Purpose: consumes tuser(SOF)/tlast(EOL) framed beats, checks them against the
//          line length and height latched at SOF, tags forwarded pixels with
//          x/y, pulses line/frame completion and resyncs after errors.
// Ports:   eim_clk/eim_rst             clock, async active-high reset
//          max_h_count/dsp_image_height frame geometry, latched at SOF
//          err_clr                      synchronous clear of err_status
//          s_axis_*                     input stream
//          m_pix_*                      forwarded pixel, x/y and handshake
//          line_done/frame_done         1-cycle completion pulses
//          frame_active                 high while a frame is being received
//          err_status                   sticky protocol error flags
//          frame_cnt                    completed frame counter
module axis_frame_receiver
  import timing_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              eim_clk,
  input  logic              eim_rst,
  input  logic [15:0]       max_h_count,
  input  logic [15:0]       dsp_image_height,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_pix_data,
  output logic              m_pix_valid,
  input  logic              m_pix_ready,
  output logic [15:0]       m_pix_x,
  output logic [15:0]       m_pix_y,
  output logic              line_done,
  output logic              frame_done,
  output logic              frame_active,
  output logic [3:0]        err_status,
  output logic [15:0]       frame_cnt
);

  rx_state_e   state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  // Geometry is kept as last-index values so end-of-line/frame is an equality test.
  logic [15:0] h_last_q, h_last_d, v_last_q, v_last_d;
  logic        line_done_q, line_done_d;
  logic        frame_done_q, frame_done_d;
  logic [3:0]  err_q, err_d, err_set;
  logic [15:0] cnt_q, cnt_d;

  logic        accept;
  logic        fwd;
  logic [15:0] pix_x, pix_y;
  logic        x_last, y_last;
  logic [15:0] sof_h_last, sof_v_last;

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign x_last     = (x_q == h_last_q);
  assign y_last     = (y_q == v_last_q);
  assign sof_h_last = clamp_min(max_h_count, MIN_H) - 16'd1;
  assign sof_v_last = clamp_min(dsp_image_height, MIN_V) - 16'd1;

  axis_pix_reg #(.DATA_W(DATA_W)) u_pix_reg (
    .clk_i       (eim_clk),
    .rst_i       (eim_rst),
    .in_valid_i  (fwd),
    .in_ready_o  (s_axis_tready),
    .in_data_i   (s_axis_tdata),
    .in_x_i      (pix_x),
    .in_y_i      (pix_y),
    .out_valid_o (m_pix_valid),
    .out_ready_i (m_pix_ready),
    .out_data_o  (m_pix_data),
    .out_x_o     (m_pix_x),
    .out_y_o     (m_pix_y)
  );

  always_ff @(posedge eim_clk or posedge eim_rst) begin
    if (eim_rst) begin
      state_q      <= RX_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      h_last_q     <= MIN_H - 16'd1;
      v_last_q     <= MIN_V - 16'd1;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      h_last_q     <= h_last_d;
      v_last_q     <= v_last_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        RX_IDLE, RX_RESYNC: begin
          if (s_axis_tuser) state_d = RX_ACTIVE;
        end
        RX_ACTIVE: begin
          if (s_axis_tuser)                 state_d = RX_ACTIVE;
          else if (s_axis_tlast && !x_last) state_d = RX_RESYNC;
          else if (x_last && !s_axis_tlast) state_d = RX_RESYNC;
          else if (x_last && y_last)        state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    fwd          = 1'b0;
    pix_x        = x_q;
    pix_y        = y_q;
    x_d          = x_q;
    y_d          = y_q;
    h_last_d     = h_last_q;
    v_last_d     = v_last_q;
    err_set      = '0;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;
    if (accept) begin
      // Any SOF beat (first, early or after resync) restarts the frame at (0,0).
      if (s_axis_tuser) begin
        fwd      = 1'b1;
        pix_x    = '0;
        pix_y    = '0;
        x_d      = 16'd1;
        y_d      = '0;
        h_last_d = sof_h_last;
        v_last_d = sof_v_last;
        if (state_q == RX_ACTIVE) err_set[ERR_EARLY_SOF] = 1'b1;
      end else begin
        case (state_q)
          RX_IDLE: err_set[ERR_ORPHAN] = 1'b1;
          RX_ACTIVE: begin
            fwd = 1'b1;
            if (s_axis_tlast && !x_last) begin
              err_set[ERR_EARLY_TLAST] = 1'b1;
            end else if (x_last && !s_axis_tlast) begin
              err_set[ERR_MISS_TLAST] = 1'b1;
            end else if (x_last) begin
              line_done_d = 1'b1;
              x_d         = '0;
              y_d         = y_q + 16'd1;
              if (y_last) begin
                frame_done_d = 1'b1;
                cnt_d        = cnt_q + 16'd1;
                y_d          = '0;
              end
            end else begin
              x_d = x_q + 16'd1;
            end
          end
          default: ;  // RESYNC drops non-SOF beats silently
        endcase
      end
    end
    // A new error event outranks a coincident clear for its own bit.
    err_d = (err_clr ? 4'b0000 : err_q) | err_set;
  end

  assign line_done    = line_done_q;
  assign frame_done   = frame_done_q;
  assign frame_active = (state_q == RX_ACTIVE);
  assign err_status   = err_q;
  assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_axis_frame_receiver.sv
// tb/tb_axis_frame_receiver.sv - directed self-checking bench for axis_frame_receiver
module tb_axis_frame_receiver;

  logic        eim_clk = 1'b0;
  logic        eim_rst = 1'b1;
  logic [15:0] max_h_count = 16'd4;
  logic [15:0] dsp_image_height = 16'd3;
  logic        err_clr = 1'b0;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [15:0] m_pix_data;
  logic        m_pix_valid;
  logic        m_pix_ready = 1'b1;
  logic [15:0] m_pix_x, m_pix_y;
  logic        line_done, frame_done, frame_active;
  logic [3:0]  err_status;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  always #5 eim_clk = ~eim_clk;

  axis_frame_receiver #(.DATA_W(16)) dut (
    .eim_clk          (eim_clk),
    .eim_rst          (eim_rst),
    .max_h_count      (max_h_count),
    .dsp_image_height (dsp_image_height),
    .err_clr          (err_clr),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tlast     (s_axis_tlast),
    .m_pix_data       (m_pix_data),
    .m_pix_valid      (m_pix_valid),
    .m_pix_ready      (m_pix_ready),
    .m_pix_x          (m_pix_x),
    .m_pix_y          (m_pix_y),
    .line_done        (line_done),
    .frame_done       (frame_done),
    .frame_active     (frame_active),
    .err_status       (err_status),
    .frame_cnt        (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat, wait (bounded) for acceptance, return at accept+1 (+1 time unit).
  task automatic send(input logic [15:0] d, input logic u, input logic l);
    int n;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 100) begin
      @(posedge eim_clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=%0d expected=<100", n);
    end
    @(posedge eim_clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    eim_rst = 1'b1;
    @(posedge eim_clk); #1;
    eim_rst = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge eim_clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic chk_pix(input string tag, input logic [15:0] d, input logic [15:0] x, input logic [15:0] y);
    chk({tag, "_valid"}, m_pix_valid, 1'b1);
    chk({tag, "_data"}, m_pix_data, d);
    chk({tag, "_x"}, m_pix_x, x);
    chk({tag, "_y"}, m_pix_y, y);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tready"}, s_axis_tready, 1'b1);
    chk({tag, "_valid"}, m_pix_valid, 1'b0);
    chk({tag, "_data"}, m_pix_data, 16'h0);
    chk({tag, "_x"}, m_pix_x, 16'h0);
    chk({tag, "_y"}, m_pix_y, 16'h0);
    chk({tag, "_line_done"}, line_done, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_active"}, frame_active, 1'b0);
    chk({tag, "_err"}, err_status, 4'h0);
    chk({tag, "_cnt"}, frame_cnt, 16'h0);
  endtask

  initial begin
    // Reset state
    #12;
    chk_reset_vals("rst");
    eim_rst = 1'b0;
    @(posedge eim_clk); #1;

    // Nominal frame H=4 V=3
    for (int i = 0; i < 12; i++) begin
      send(16'h0100 + 16'(i), i == 0, (i % 4) == 3);
      chk_pix($sformatf("nom%0d", i), 16'h0100 + 16'(i), 16'(i % 4), 16'(i / 4));
      chk($sformatf("nom%0d_line_done", i), line_done, (i % 4) == 3);
      chk($sformatf("nom%0d_frame_done", i), frame_done, i == 11);
      chk($sformatf("nom%0d_active", i), frame_active, i != 11);
    end
    chk("nom_cnt", frame_cnt, 16'd1);
    chk("nom_err", err_status, 4'h0);
    @(posedge eim_clk); #1;
    chk("nom_idle_valid", m_pix_valid, 1'b0);
    chk("nom_pulse_gone", frame_done, 1'b0);

    // Early tlast on x=2 of line 0
    send(16'h0200, 1'b1, 1'b0);
    send(16'h0201, 1'b0, 1'b0);
    send(16'h0202, 1'b0, 1'b1);
    chk_pix("etl", 16'h0202, 16'd2, 16'd0);
    chk("etl_err", err_status, 4'b0010);
    chk("etl_active", frame_active, 1'b0);
    chk("etl_line_done", line_done, 1'b0);
    send(16'h0203, 1'b0, 1'b0);
    chk("etl_drop1_valid", m_pix_valid, 1'b0);
    send(16'h0204, 1'b0, 1'b1);
    chk("etl_drop2_valid", m_pix_valid, 1'b0);
    chk("etl_drop_err", err_status, 4'b0010);
    send(16'h0210, 1'b1, 1'b0);
    chk_pix("etl_sof", 16'h0210, 16'd0, 16'd0);
    chk("etl_sof_active", frame_active, 1'b1);
    pulse_clr();
    chk("etl_clr", err_status, 4'h0);

    // Missing tlast at x=3 (continuing the frame just started)
    send(16'h0211, 1'b0, 1'b0);
    send(16'h0212, 1'b0, 1'b0);
    send(16'h0213, 1'b0, 1'b0);
    chk_pix("mtl", 16'h0213, 16'd3, 16'd0);
    chk("mtl_err", err_status, 4'b0100);
    chk("mtl_active", frame_active, 1'b0);
    chk("mtl_line_done", line_done, 1'b0);
    chk("mtl_cnt", frame_cnt, 16'd1);

    // Early SOF at (2,1)
    do_reset();
    chk("esof_rst_err", err_status, 4'h0);
    for (int i = 0; i < 6; i++) send(16'h0300 + 16'(i), i == 0, i == 3);
    send(16'h0310, 1'b1, 1'b0);
    chk_pix("esof", 16'h0310, 16'd0, 16'd0);
    chk("esof_err", err_status, 4'b1000);
    chk("esof_frame_done", frame_done, 1'b0);
    chk("esof_active", frame_active, 1'b1);
    for (int i = 1; i < 12; i++) begin
      send(16'h0310 + 16'(i), 1'b0, (i % 4) == 3);
      chk($sformatf("esof%0d_frame_done", i), frame_done, i == 11);
    end
    chk_pix("esof_last", 16'h031B, 16'd3, 16'd2);
    chk("esof_cnt", frame_cnt, 16'd1);

    // Orphans in IDLE, then backpressure with m_pix_ready 1,0,0,1 (H=4 V=1)
    pulse_clr();
    dsp_image_height = 16'd1;
    for (int i = 0; i < 3; i++) begin
      send(16'h0400 + 16'(i), 1'b0, 1'b0);
      chk($sformatf("orph%0d_valid", i), m_pix_valid, 1'b0);
    end
    chk("orph_err", err_status, 4'b0001);
    send(16'h0410, 1'b1, 1'b0);
    chk_pix("bp0", 16'h0410, 16'd0, 16'd0);
    m_pix_ready   = 1'b0;
    s_axis_tdata  = 16'h0411;
    s_axis_tvalid = 1'b1;
    #1;
    chk("bp_tready_lo0", s_axis_tready, 1'b0);
    @(posedge eim_clk); #1;
    chk_pix("bp_hold1", 16'h0410, 16'd0, 16'd0);
    chk("bp_tready_lo1", s_axis_tready, 1'b0);
    @(posedge eim_clk); #1;
    chk_pix("bp_hold2", 16'h0410, 16'd0, 16'd0);
    chk("bp_tready_lo2", s_axis_tready, 1'b0);
    m_pix_ready = 1'b1;
    #1;
    chk("bp_tready_hi", s_axis_tready, 1'b1);
    @(posedge eim_clk); #1;
    s_axis_tvalid = 1'b0;
    chk_pix("bp1", 16'h0411, 16'd1, 16'd0);
    send(16'h0412, 1'b0, 1'b0);
    chk_pix("bp2", 16'h0412, 16'd2, 16'd0);
    send(16'h0413, 1'b0, 1'b1);
    chk_pix("bp3", 16'h0413, 16'd3, 16'd0);
    chk("bp_frame_done", frame_done, 1'b1);
    chk("bp_cnt", frame_cnt, 16'd2);
    chk("bp_err", err_status, 4'b0001);

    // Asynchronous reset mid-frame at (1,1)
    pulse_clr();
    dsp_image_height = 16'd3;
    for (int i = 0; i < 6; i++) send(16'h0500 + 16'(i), i == 0, i == 3);
    chk_pix("mid", 16'h0505, 16'd1, 16'd1);
    #2;
    eim_rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    #1;
    eim_rst = 1'b0;
    @(posedge eim_clk); #1;
    for (int i = 0; i < 12; i++) send(16'h0600 + 16'(i), i == 0, (i % 4) == 3);
    chk_pix("post_rst_last", 16'h060B, 16'd3, 16'd2);
    chk("post_rst_frame_done", frame_done, 1'b1);
    chk("post_rst_cnt", frame_cnt, 16'd1);

    // Clamps: H=1 -> 2, V=0 -> 1; latched at SOF, later changes ignored
    max_h_count      = 16'd1;
    dsp_image_height = 16'd0;
    send(16'h0700, 1'b1, 1'b0);
    max_h_count      = 16'd8;
    dsp_image_height = 16'd5;
    send(16'h0701, 1'b0, 1'b1);
    chk_pix("clamp", 16'h0701, 16'd1, 16'd0);
    chk("clamp_frame_done", frame_done, 1'b1);
    chk("clamp_cnt", frame_cnt, 16'd2);
    chk("clamp_err", err_status, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
